// File: rtl/debug_state_dumper.sv
// Snapshot engine: on trigger or power-up timeout, reads the register file and char memory
// and streams a framed byte image (A5 .. payload .. 5A) over a valid/ready byte interface.
module debug_state_dumper #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned REG_AW    = 5,
   parameter int unsigned MEM_COUNT = 19,
   parameter int unsigned MEM_AW    = 5,
   parameter int unsigned MEM_W     = 8,
   parameter int unsigned TIMEOUT   = 250000,
   parameter int unsigned TIMEOUT_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              trigger_i,
   output logic              reg_rd_o,
   output logic [REG_AW-1:0] reg_addr_o,
   input  logic [DATA_W-1:0] reg_data_i,
   output logic              mem_rd_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   input  logic [MEM_W-1:0]  mem_data_i,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned REG_BYTES = DATA_W / 8;
   localparam int unsigned MEM_BYTES = MEM_W / 8;
   localparam int unsigned SH_W      = (DATA_W > MEM_W) ? DATA_W : MEM_W;
   localparam int unsigned SH_BYTES  = SH_W / 8;
   localparam int unsigned BI_W      = (SH_BYTES > 1) ? $clog2(SH_BYTES) : 1;
   localparam int unsigned REG_LAST  = REG_COUNT - 1;
   localparam int unsigned MEM_LAST  = (MEM_COUNT > 0) ? MEM_COUNT - 1 : 0;
   localparam int unsigned TO_LAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic        HAS_MEM   = (MEM_COUNT != 0);
   localparam logic        TO_EN     = (TIMEOUT != 0);
   localparam logic [7:0]  BYTE_SOF  = 8'hA5;
   localparam logic [7:0]  BYTE_EOF  = 8'h5A;

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_REG_RD, S_REG_WAIT, S_REG_TX,
      S_MEM_RD, S_MEM_WAIT, S_MEM_TX, S_END
   } state_e;

   state_e               state_q, state_d;
   logic [REG_AW-1:0]    reg_idx_q, reg_idx_d;
   logic [MEM_AW-1:0]    mem_idx_q, mem_idx_d;
   logic [BI_W-1:0]      byte_idx_q, byte_idx_d;
   logic [SH_W-1:0]      shift_q, shift_d;
   logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
   logic                 to_armed_q, to_armed_d;
   logic                 to_pend_q, to_pend_d;
   logic                 reg_rd_q, reg_rd_d;
   logic [REG_AW-1:0]    reg_addr_q, reg_addr_d;
   logic                 mem_rd_q, mem_rd_d;
   logic [MEM_AW-1:0]    mem_addr_q, mem_addr_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic accept_c;
   logic to_fire_c;
   logic req_c;
   logic reg_last_byte_c, reg_last_word_c;
   logic mem_last_byte_c, mem_last_word_c;

   assign accept_c        = tx_valid_q && tx_ready_i;
   assign to_fire_c       = TO_EN && to_armed_q && (to_cnt_q == TIMEOUT_W'(TO_LAST));
   assign req_c           = trigger_i || to_pend_q || to_fire_c;
   assign reg_last_byte_c = (byte_idx_q == BI_W'(REG_BYTES - 1));
   assign reg_last_word_c = (reg_idx_q == REG_AW'(REG_LAST));
   assign mem_last_byte_c = (byte_idx_q == BI_W'(MEM_BYTES - 1));
   assign mem_last_word_c = (mem_idx_q == MEM_AW'(MEM_LAST));

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (req_c) state_d = S_START;
         S_START:    if (accept_c) state_d = S_REG_RD;
         S_REG_RD:   state_d = S_REG_WAIT;
         S_REG_WAIT: state_d = S_REG_TX;
         S_REG_TX: begin
            if (accept_c && reg_last_byte_c) begin
               if (!reg_last_word_c) state_d = S_REG_RD;
               else if (HAS_MEM)     state_d = S_MEM_RD;
               else                  state_d = S_END;
            end
         end
         S_MEM_RD:   state_d = S_MEM_WAIT;
         S_MEM_WAIT: state_d = S_MEM_TX;
         S_MEM_TX: begin
            if (accept_c && mem_last_byte_c)
               state_d = mem_last_word_c ? S_END : S_MEM_RD;
         end
         S_END:      if (accept_c) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Datapath and registered-output next values
   always_comb begin
      reg_idx_d  = reg_idx_q;
      mem_idx_d  = mem_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      to_cnt_d   = to_cnt_q;
      to_armed_d = to_armed_q;
      to_pend_d  = to_pend_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_REG_WAIT: begin
            shift_d = '0;
            shift_d[SH_W-1 -: DATA_W] = reg_data_i;
         end
         S_MEM_WAIT: begin
            shift_d = '0;
            shift_d[SH_W-1 -: MEM_W] = mem_data_i;
         end
         S_REG_TX: begin
            if (accept_c) begin
               shift_d = shift_q << 8;
               if (reg_last_byte_c) begin
                  byte_idx_d = '0;
                  reg_idx_d  = reg_last_word_c ? '0 : reg_idx_q + REG_AW'(1);
               end else begin
                  byte_idx_d = byte_idx_q + BI_W'(1);
               end
            end
         end
         S_MEM_TX: begin
            if (accept_c) begin
               shift_d = shift_q << 8;
               if (mem_last_byte_c) begin
                  byte_idx_d = '0;
                  mem_idx_d  = mem_last_word_c ? '0 : mem_idx_q + MEM_AW'(1);
               end else begin
                  byte_idx_d = byte_idx_q + BI_W'(1);
               end
            end
         end
         S_END:   done_d = accept_c;
         default: ;
      endcase

      // One-shot timeout; a firing seen outside IDLE is parked until the engine is free
      if (TO_EN && to_armed_q) begin
         if (to_fire_c) begin
            to_armed_d = 1'b0;
            if (state_q != S_IDLE) to_pend_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
         end
      end
      if (state_q == S_IDLE && req_c) to_pend_d = 1'b0;

      busy_d     = (state_d != S_IDLE);
      reg_rd_d   = (state_d == S_REG_RD);
      mem_rd_d   = (state_d == S_MEM_RD);
      reg_addr_d = (state_d == S_REG_RD) ? reg_idx_d : reg_addr_q;
      mem_addr_d = (state_d == S_MEM_RD) ? mem_idx_d : mem_addr_q;
      tx_valid_d = (state_d == S_START) || (state_d == S_REG_TX) ||
                   (state_d == S_MEM_TX) || (state_d == S_END);
      unique case (state_d)
         S_START:            tx_data_d = BYTE_SOF;
         S_END:              tx_data_d = BYTE_EOF;
         S_REG_TX, S_MEM_TX: tx_data_d = shift_d[SH_W-1 -: 8];
         default:            tx_data_d = 8'h00;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         reg_idx_q  <= '0;
         mem_idx_q  <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         to_cnt_q   <= '0;
         to_armed_q <= 1'b1;
         to_pend_q  <= 1'b0;
         reg_rd_q   <= 1'b0;
         reg_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         reg_idx_q  <= reg_idx_d;
         mem_idx_q  <= mem_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         to_cnt_q   <= to_cnt_d;
         to_armed_q <= to_armed_d;
         to_pend_q  <= to_pend_d;
         reg_rd_q   <= reg_rd_d;
         reg_addr_q <= reg_addr_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign reg_rd_o   = reg_rd_q;
   assign reg_addr_o = reg_addr_q;
   assign mem_rd_o   = mem_rd_q;
   assign mem_addr_o = mem_addr_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_debug_state_dumper.sv
// Scoreboard bench for debug_state_dumper: three instances (trigger-only, timeout=100, no char memory).
module tb_debug_state_dumper;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rstn, trig, ready;
   logic [2:0] reg_rd, mem_rd, tx_valid, busy, done;
   logic [4:0] reg_addr [3];
   logic [4:0] mem_addr [3];
   logic [31:0] reg_data [3];
   logic [7:0]  mem_data [3];
   logic [7:0]  tx_data  [3];

   logic [31:0] regs  [2] = '{32'h11223344, 32'hDEADBEEF};
   logic [7:0]  chars [3] = '{8'h48, 8'h69, 8'h21};

   logic [7:0] exp_q [3][$];
   int rx_cnt [3] = '{0, 0, 0};
   int done_cnt [3] = '{0, 0, 0};
   int mem_rd2_cnt = 0;
   logic [2:0] hold_q = 3'b000;
   logic [7:0] hold_data [3];
   logic rand_en;

   int n_tests = 0;
   int n_fail  = 0;

   debug_state_dumper #(.DATA_W(32), .REG_COUNT(2), .REG_AW(5), .MEM_COUNT(3), .MEM_AW(5),
                        .MEM_W(8), .TIMEOUT(0), .TIMEOUT_W(32)) u_dut0 (
      .clk(clk), .resetn(rstn[0]), .trigger_i(trig[0]),
      .reg_rd_o(reg_rd[0]), .reg_addr_o(reg_addr[0]), .reg_data_i(reg_data[0]),
      .mem_rd_o(mem_rd[0]), .mem_addr_o(mem_addr[0]), .mem_data_i(mem_data[0]),
      .tx_data_o(tx_data[0]), .tx_valid_o(tx_valid[0]), .tx_ready_i(ready[0]),
      .busy_o(busy[0]), .done_o(done[0]));

   debug_state_dumper #(.DATA_W(32), .REG_COUNT(2), .REG_AW(5), .MEM_COUNT(3), .MEM_AW(5),
                        .MEM_W(8), .TIMEOUT(100), .TIMEOUT_W(32)) u_dut1 (
      .clk(clk), .resetn(rstn[1]), .trigger_i(trig[1]),
      .reg_rd_o(reg_rd[1]), .reg_addr_o(reg_addr[1]), .reg_data_i(reg_data[1]),
      .mem_rd_o(mem_rd[1]), .mem_addr_o(mem_addr[1]), .mem_data_i(mem_data[1]),
      .tx_data_o(tx_data[1]), .tx_valid_o(tx_valid[1]), .tx_ready_i(ready[1]),
      .busy_o(busy[1]), .done_o(done[1]));

   debug_state_dumper #(.DATA_W(32), .REG_COUNT(2), .REG_AW(5), .MEM_COUNT(0), .MEM_AW(5),
                        .MEM_W(8), .TIMEOUT(0), .TIMEOUT_W(32)) u_dut2 (
      .clk(clk), .resetn(rstn[2]), .trigger_i(trig[2]),
      .reg_rd_o(reg_rd[2]), .reg_addr_o(reg_addr[2]), .reg_data_i(reg_data[2]),
      .mem_rd_o(mem_rd[2]), .mem_addr_o(mem_addr[2]), .mem_data_i(mem_data[2]),
      .tx_data_o(tx_data[2]), .tx_valid_o(tx_valid[2]), .tx_ready_i(ready[2]),
      .busy_o(busy[2]), .done_o(done[2]));

   // Register file and char memory models: one-cycle read latency
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reg_rd[i]) reg_data[i] <= (reg_addr[i] < 5'd2) ? regs[reg_addr[i][0]] : 32'h0;
         if (mem_rd[i]) mem_data[i] <= (mem_addr[i] < 5'd3) ? chars[mem_addr[i][1:0]] : 8'h00;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transfer monitor on the falling edge; a byte seen here moves on the next rising edge
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         logic [7:0] e;
         if (hold_q[i]) begin
            check_eq("hold_valid", 32'(tx_valid[i]), 32'd1);
            check_eq("hold_data", 32'(tx_data[i]), 32'(hold_data[i]));
         end
         if (tx_valid[i] && ready[i]) begin
            if (exp_q[i].size() == 0) begin
               check_eq("byte_expected", 32'(exp_q[i].size()), 32'd1);
            end else begin
               e = exp_q[i].pop_front();
               check_eq("stream_byte", 32'(tx_data[i]), 32'(e));
            end
            rx_cnt[i] <= rx_cnt[i] + 1;
         end
         if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
         hold_q[i]    <= tx_valid[i] && !ready[i];
         hold_data[i] <= tx_data[i];
      end
      if (mem_rd[2]) mem_rd2_cnt <= mem_rd2_cnt + 1;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      if (rand_en) ready[0] = 1'($urandom_range(0, 1));
   endtask

   task automatic push_frame(input int i);
      exp_q[i].push_back(8'hA5);
      for (int r = 0; r < 2; r++)
         for (int b = 3; b >= 0; b--) exp_q[i].push_back(regs[r][8*b +: 8]);
      if (i != 2)
         for (int m = 0; m < 3; m++) exp_q[i].push_back(chars[m]);
      exp_q[i].push_back(8'h5A);
   endtask

   task automatic pulse(input int i);
      trig[i] = 1'b1;
      cycle();
      trig[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int target, input int budget);
      int n = 0;
      while (done_cnt[i] < target && n < budget) begin
         cycle();
         n++;
      end
      if (done_cnt[i] < target) check_eq("done_timeout", 32'(done_cnt[i]), 32'(target));
   endtask

   task automatic wait_bytes(input int i, input int target, input int budget);
      int n = 0;
      while (rx_cnt[i] < target && n < budget) begin
         cycle();
         n++;
      end
      if (rx_cnt[i] < target) check_eq("bytes_timeout", 32'(rx_cnt[i]), 32'(target));
   endtask

   initial begin
      int base;
      rstn = 3'b000; trig = 3'b000; ready = 3'b111; rand_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rd", 32'({reg_rd, mem_rd}), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_tx_data", 32'({tx_data[0], tx_data[1], tx_data[2]}), 32'd0);

      // Timeout instance starts on cycle 100 after release, once
      push_frame(1);
      rstn = 3'b111;
      for (int k = 1; k <= 100; k++) begin
         cycle();
         if (k == 99)  check_eq("to_idle_c99", 32'(busy[1]), 32'd0);
         if (k == 100) check_eq("to_start_c100", 32'(busy[1]), 32'd1);
      end
      wait_done(1, 1, 200);
      repeat (1000) cycle();
      check_eq("to_one_frame", 32'(done_cnt[1]), 32'd1);
      check_eq("to_bytes", 32'(rx_cnt[1]), 32'd13);
      check_eq("to_q_empty", 32'(exp_q[1].size()), 32'd0);
      check_eq("no_to_quiet", 32'(done_cnt[0] + done_cnt[2]), 32'd0);

      // Plain trigger, sink always ready
      push_frame(0);
      pulse(0);
      wait_done(0, 1, 200);
      check_eq("trig_bytes", 32'(rx_cnt[0]), 32'd13);
      check_eq("trig_q_empty", 32'(exp_q[0].size()), 32'd0);

      // Back-pressure from a randomly toggling sink
      rand_en = 1'b1;
      push_frame(0);
      pulse(0);
      wait_done(0, 2, 2000);
      rand_en = 1'b0;
      ready[0] = 1'b1;
      check_eq("bp_q_empty", 32'(exp_q[0].size()), 32'd0);
      check_eq("bp_bytes", 32'(rx_cnt[0]), 32'd26);

      // Trigger while busy is dropped
      base = rx_cnt[0];
      push_frame(0);
      pulse(0);
      wait_bytes(0, base + 5, 200);
      pulse(0);
      wait_done(0, 3, 200);
      repeat (50) cycle();
      check_eq("busy_trig_frames", 32'(done_cnt[0]), 32'd3);
      check_eq("busy_trig_idle", 32'(busy[0]), 32'd0);
      check_eq("busy_trig_q", 32'(exp_q[0].size()), 32'd0);

      // Reset mid-frame after byte 7
      base = rx_cnt[0];
      push_frame(0);
      pulse(0);
      wait_bytes(0, base + 7, 200);
      rstn[0] = 1'b0;
      #1;
      check_eq("arst_outs", 32'({tx_valid[0], busy[0], reg_rd[0], mem_rd[0], done[0]}), 32'd0);
      check_eq("arst_data", 32'(tx_data[0]), 32'd0);
      exp_q[0].delete();
      repeat (3) cycle();
      rstn[0] = 1'b1;
      cycle();
      check_eq("arst_no_end", 32'(done_cnt[0]), 32'd3);
      check_eq("arst_bytes", 32'(rx_cnt[0] - base), 32'd7);
      push_frame(0);
      pulse(0);
      wait_done(0, 4, 200);
      check_eq("arst_refill_q", 32'(exp_q[0].size()), 32'd0);
      check_eq("arst_refill_bytes", 32'(rx_cnt[0] - base), 32'd20);

      // Timeout landing inside a trigger-started dump is served afterwards
      rstn[1] = 1'b0;
      cycle();
      push_frame(1);
      push_frame(1);
      rstn[1] = 1'b1;
      repeat (89) cycle();
      pulse(1);
      wait_done(1, 3, 300);
      repeat (100) cycle();
      check_eq("to_queued_frames", 32'(done_cnt[1]), 32'd3);
      check_eq("to_queued_q", 32'(exp_q[1].size()), 32'd0);
      check_eq("to_queued_bytes", 32'(rx_cnt[1]), 32'd39);

      // No char memory: registers only
      push_frame(2);
      pulse(2);
      wait_done(2, 1, 200);
      repeat (5) cycle();
      check_eq("nomem_bytes", 32'(rx_cnt[2]), 32'd10);
      check_eq("nomem_q", 32'(exp_q[2].size()), 32'd0);
      check_eq("nomem_no_rd", 32'(mem_rd2_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
